// File: rtl/uart_tx_fifo.sv
// Bus-written byte FIFO drained by a UART serialiser onto txd (8N1 by default).
// Optional feature macro: UART_PARITY_EN -> 8E1 framing with an even-parity bit.
module uart_tx_fifo #(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        RSTN,
  input  logic        EN,
  input  logic [31:0] P_Data,
  output logic        txd,
  output logic [31:0] status,
  output logic        full,
  output logic        empty,
  output logic        busy
);

  localparam int unsigned Div  = CLK_HZ / BAUD;
  localparam int unsigned Aw   = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = $clog2(Div);
  localparam logic [CntW-1:0] CntLast = CntW'(Div - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop
`ifdef UART_PARITY_EN
    , StPar
`endif
  } state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [2:0]      bit_idx_q;
  logic [7:0]      shift_q;
  logic            txd_q, busy_q;
`ifdef UART_PARITY_EN
  logic            par_q;
`endif

  logic [7:0]  mem [FIFO_DEPTH];
  logic [Aw:0] wr_ptr_q, rd_ptr_q, wr_ptr_d, rd_ptr_d, used_d;
  logic [7:0]  used_ext, rd_data;
  logic [3:0]  count_q, count_d;
  logic        full_q, empty_q, full_d, empty_d, ovf_q;
  logic        is_cmd, push, pop, bit_end;
  logic        unused_pdata;

  assign unused_pdata = ^P_Data[30:8];

  always_comb begin
    is_cmd   = P_Data[31];
    // full_q is the pre-pop view, so a write on the popping cycle is still dropped.
    push     = EN & ~is_cmd & ~full_q;
    pop      = (state_q == StIdle) & ~empty_q;
    wr_ptr_d = wr_ptr_q + {{Aw{1'b0}}, push};
    rd_ptr_d = rd_ptr_q + {{Aw{1'b0}}, pop};
    used_d   = wr_ptr_d - rd_ptr_d;
    used_ext = 8'(used_d);
    count_d  = (used_ext > 8'd15) ? 4'hF : used_ext[3:0];
    full_d   = (wr_ptr_d[Aw] != rd_ptr_d[Aw]) && (wr_ptr_d[Aw-1:0] == rd_ptr_d[Aw-1:0]);
    empty_d  = (wr_ptr_d == rd_ptr_d);
    rd_data  = mem[rd_ptr_q[Aw-1:0]];
    bit_end  = (cnt_q == CntLast);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q[Aw-1:0]] <= P_Data[7:0];
    end
  end

  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      count_q  <= count_d;
      if (EN && is_cmd) begin
        ovf_q <= 1'b0;
      end else if (EN && full_q) begin
        ovf_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      txd_q     <= 1'b1;
      busy_q    <= 1'b0;
`ifdef UART_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          if (pop) begin
            shift_q <= rd_data;
`ifdef UART_PARITY_EN
            par_q   <= ^rd_data;
`endif
            state_q <= StStart;
            cnt_q   <= '0;
            txd_q   <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        StStart: begin
          if (bit_end) begin
            state_q   <= StData;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            txd_q     <= shift_q[0];
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StData: begin
          if (bit_end) begin
            cnt_q <= '0;
            if (bit_idx_q == 3'd7) begin
`ifdef UART_PARITY_EN
              state_q <= StPar;
              txd_q   <= par_q;
`else
              state_q <= StStop;
              txd_q   <= 1'b1;
`endif
            end else begin
              bit_idx_q <= bit_idx_q + 1'b1;
              shift_q   <= shift_q >> 1;
              txd_q     <= shift_q[1];
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
`ifdef UART_PARITY_EN
        StPar: begin
          if (bit_end) begin
            state_q <= StStop;
            cnt_q   <= '0;
            txd_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
`endif
        StStop: begin
          if (bit_end) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            txd_q   <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          cnt_q   <= '0;
          txd_q   <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign txd    = txd_q;
  assign busy   = busy_q;
  assign full   = full_q;
  assign empty  = empty_q;
  assign status = {24'b0, ovf_q, busy_q, full_q, empty_q, count_q};

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: accepted bytes queue up, a line monitor decodes txd.
module tb_uart_tx_fifo;

  localparam int unsigned Div = 16;

  logic        clk = 1'b0;
  logic        RSTN = 1'b0;
  logic        EN = 1'b0;
  logic [31:0] P_Data = '0;
  logic        txd, full, empty, busy;
  logic [31:0] status;

  int vecs = 0;
  int errs = 0;
  int cyc = 0;
  int rst_cnt = 0;
  logic [7:0] sb[$];
  int starts[$];

  uart_tx_fifo #(
    .CLK_HZ    (16),
    .BAUD      (1),
    .FIFO_DEPTH(4)
  ) dut (
    .clk   (clk),
    .RSTN  (RSTN),
    .EN    (EN),
    .P_Data(P_Data),
    .txd   (txd),
    .status(status),
    .full  (full),
    .empty (empty),
    .busy  (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge RSTN) rst_cnt = rst_cnt + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%h, required 0x%h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive one write for a cycle; accepted bytes are what the line must later carry.
  task automatic wr(input logic [31:0] d, input bit accept);
    EN = 1'b1;
    P_Data = d;
    if (accept) sb.push_back(d[7:0]);
    step(1);
    EN = 1'b0;
    P_Data = '0;
  endtask

  initial begin : monitor
    logic [7:0] rx;
    logic [7:0] exp_b;
    logic st, sp, pb;
    int r0, t0;
    pb = 1'b0;
    forever begin
      @(negedge clk);
      if (RSTN === 1'b1 && txd === 1'b0) begin
        r0 = rst_cnt;
        t0 = cyc;
        repeat (Div / 2) @(negedge clk);
        st = txd;
        for (int i = 0; i < 8; i++) begin
          repeat (Div) @(negedge clk);
          rx[i] = txd;
        end
`ifdef UART_PARITY_EN
        repeat (Div) @(negedge clk);
        pb = txd;
`endif
        repeat (Div) @(negedge clk);
        sp = txd;
        if (rst_cnt == r0) begin
          starts.push_back(t0);
          if (sb.size() == 0) begin
            vecs++;
            errs++;
            $display("FAIL rx_unexpected: got byte 0x%h, required no frame", rx);
          end else begin
            exp_b = sb.pop_front();
            check("rx_byte", {24'b0, rx}, {24'b0, exp_b});
            check("rx_start", {31'b0, st}, 32'd0);
            check("rx_stop", {31'b0, sp}, 32'd1);
`ifdef UART_PARITY_EN
            check("rx_parity", {31'b0, pb}, {31'b0, ^exp_b});
`endif
          end
        end
      end
    end
  end

  initial begin : stim
    int lows;
    // Reset and idle
    step(3);
    @(negedge clk);
    RSTN = 1'b1;
    step(50);
    check("idle_txd", {31'b0, txd}, 32'd1);
    check("idle_status", status, 32'h0000_0010);
    check("idle_flags", {29'b0, full, empty, busy}, 32'b010);

    // Single byte: latency and frame length
    wr(32'h0000_00A5, 1'b1);
    check("n1_status", status, 32'h0000_0001);
    check("n1_txd", {31'b0, txd}, 32'd1);
    step(1);
    check("n2_txd", {31'b0, txd}, 32'd0);
    check("n2_status", status, 32'h0000_0050);
    step(15);
    check("n17_txd", {31'b0, txd}, 32'd0);
    step(1);
    check("n18_txd_bit0", {31'b0, txd}, 32'd1);
    step(143);
    check("n161_busy", {31'b0, busy}, 32'd1);
    check("n161_txd", {31'b0, txd}, 32'd1);
    step(1);
    check("n162_status", status, 32'h0000_0010);
    step(20);

    // Overflow: 0x5A keeps the serialiser busy so 0x01..0x04 fill the FIFO
    starts.delete();
    wr(32'h0000_005A, 1'b1);
    wr(32'h0000_0001, 1'b1);
    wr(32'h0000_0002, 1'b1);
    wr(32'h0000_0003, 1'b1);
    wr(32'h0000_0004, 1'b1);
    wr(32'h0000_0005, 1'b0);
    check("ovf_status", status, 32'h0000_00E4);
    wr(32'h8000_0000, 1'b0);
    check("ovf_clear_status", status, 32'h0000_0064);
    step(850);
    check("b2b_frames", 32'(starts.size()), 32'd5);
    if (starts.size() == 5) begin
      for (int i = 0; i < 4; i++) begin
        check("b2b_gap", 32'(starts[i+1] - starts[i]), 32'd161);
      end
    end

    // Write on the exact IDLE pop cycle while full
    wr(32'h0000_0011, 1'b1);
    wr(32'h0000_0022, 1'b1);
    wr(32'h0000_0033, 1'b1);
    wr(32'h0000_0044, 1'b1);
    wr(32'h0000_0055, 1'b1);
    check("fill_status", status, 32'h0000_0064);
    step(157);
    check("pop_cycle_status", status, 32'h0000_0024);
    wr(32'h0000_0066, 1'b0);
    check("prepop_drop_status", status, 32'h0000_00C3);
    wr(32'h0000_0077, 1'b1);
    check("after_pop_write_status", status, 32'h0000_00E4);
    step(850);

    // Reset in data bit 3 of 0x3C; the frame is abandoned
    wr(32'h0000_003C, 1'b0);
    step(69);
    check("pre_reset_busy", {31'b0, busy}, 32'd1);
    RSTN = 1'b0;
    #1;
    check("reset_txd", {31'b0, txd}, 32'd1);
    check("reset_status", status, 32'h0000_0010);
    step(3);
    @(negedge clk);
    RSTN = 1'b1;
    sb.delete();
    lows = 0;
    repeat (200) begin
      @(negedge clk);
      if (txd !== 1'b1) lows++;
    end
    check("no_residual_frame", 32'(lows), 32'd0);
    check("post_reset_status", status, 32'h0000_0010);

`ifdef UART_PARITY_EN
    step(1);
    wr(32'h0000_0007, 1'b1);
    step(176);
    check("par_frame_busy_end", {31'b0, busy}, 32'd1);
    step(1);
    check("par_frame_idle", {31'b0, busy}, 32'd0);
    wr(32'h0000_0003, 1'b1);
    step(200);
`endif

    step(20);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
